lsu_aligned: RTL and testbench

LSU_ALIGNED -- requirements
Module: lsu_aligned

---
 rtl/lsu_aligned_if.sv | 41 ++++
 rtl/lsu_aligned.sv | 139 +++++++++++++
 tb/tb_lsu_aligned.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_aligned_if.sv
// Core-side request/response and memory-side bus signals of the aligned load/store unit.
// The slave modport is the LSU's view; master is the core plus memory driving it.
interface lsu_aligned_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [1:0]          req_size;
  logic                req_unsigned;
  logic [ADDR_W-1:0]   req_addr;
  logic [XLEN-1:0]     req_wdata;

  logic                bus_valid;
  logic                bus_ready;
  logic [ADDR_W-1:0]   bus_addr;
  logic                bus_write;
  logic [XLEN/8-1:0]   bus_byte_en;
  logic [XLEN-1:0]     bus_wdata;
  logic [XLEN-1:0]     bus_rdata;

  logic                resp_valid;
  logic [XLEN-1:0]     resp_rdata;
  logic [1:0]          resp_err;
  logic                busy;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  bus_ready, bus_rdata,
    output req_ready, bus_valid, bus_addr, bus_write, bus_byte_en, bus_wdata,
    output resp_valid, resp_rdata, resp_err, busy
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output bus_ready, bus_rdata,
    input  req_ready, bus_valid, bus_addr, bus_write, bus_byte_en, bus_wdata,
    input  resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/lsu_aligned.sv
// Aligned load/store unit: accept -> bus one cycle later -> one-cycle response after bus_ready
// (errors respond at accept+1); one request in flight, held off with req_ready=0 while busy.
module lsu_aligned #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic        clk,
  input logic        rst,
  lsu_aligned_if.slave io
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        err_q, err_d;
  logic              write_q, uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [NB-1:0]     be_q;
  logic [XLEN-1:0]   wdata_q, rdata_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              rdy, accept, illegal, misal, tmo;
  logic [OFF_W-1:0]  req_off, off_q;
  logic [NB-1:0]     size_be;
  logic [XLEN-1:0]   sh, lmask, ld;
  logic              sbit;

  assign rdy     = (state_q == IDLE) && rst;
  assign accept  = io.req_valid && rdy;
  assign req_off = io.req_addr[OFF_W-1:0];
  assign off_q   = addr_q[OFF_W-1:0];
  assign illegal = (io.req_size == 2'b11) && (XLEN == 32);
  assign tmo     = (TIMEOUT > 0) && (cnt_q == TO_LAST);

  always_comb begin
    misal   = 1'b0;
    size_be = '0;
    case (io.req_size)
      2'b00: begin misal = 1'b0;                  size_be = NB'(8'h01); end
      2'b01: begin misal = io.req_addr[0];        size_be = NB'(8'h03); end
      2'b10: begin misal = |io.req_addr[1:0];     size_be = NB'(8'h0F); end
      default: begin misal = |io.req_addr[2:0];   size_be = NB'(8'hFF); end
    endcase
  end

  // Right-justify the selected lanes, then extend from the access size's top bit.
  always_comb begin
    sh    = io.bus_rdata >> {off_q, 3'b000};
    lmask = '1;
    sbit  = sh[XLEN-1];
    case (size_q)
      2'b00: begin lmask = XLEN'(8'hFF);         sbit = sh[7];  end
      2'b01: begin lmask = XLEN'(16'hFFFF);      sbit = sh[15]; end
      2'b10: begin lmask = XLEN'(32'hFFFF_FFFF); sbit = sh[31]; end
      default: begin lmask = '1;                 sbit = sh[XLEN-1]; end
    endcase
    ld = (sh & lmask) | ((!uns_q && sbit) ? ~lmask : '0);
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (illegal) begin
            state_d = RESP;
            err_d   = 2'b11;
          end else if (misal) begin
            state_d = RESP;
            err_d   = 2'b01;
          end else begin
            state_d = BUS;
            err_d   = 2'b00;
          end
        end
      end
      BUS: begin
        // bus_ready takes priority over an expiring timeout in the same cycle.
        if (io.bus_ready) begin
          state_d = RESP;
          err_d   = 2'b00;
        end else if (tmo) begin
          state_d = RESP;
          err_d   = 2'b10;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      err_q   <= 2'b00;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= (state_q == BUS) ? cnt_q + 1'b1 : '0;
      if (accept) begin
        write_q <= io.req_write;
        uns_q   <= io.req_unsigned;
        size_q  <= io.req_size;
        addr_q  <= io.req_addr;
        be_q    <= size_be << req_off;
        wdata_q <= io.req_wdata << {req_off, 3'b000};
        rdata_q <= '0;
      end
      if ((state_q == BUS) && io.bus_ready && !write_q) begin
        rdata_q <= ld;
      end
    end
  end

  assign io.req_ready   = rdy;
  assign io.bus_valid   = (state_q == BUS);
  assign io.bus_write   = io.bus_valid && write_q;
  assign io.bus_byte_en = io.bus_valid ? be_q : '0;
  assign io.bus_addr    = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign io.bus_wdata   = wdata_q;
  assign io.resp_valid  = (state_q == RESP);
  assign io.resp_rdata  = io.resp_valid ? rdata_q : '0;
  assign io.resp_err    = io.resp_valid ? err_q : 2'b00;
  assign io.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_lsu_aligned.sv
// Drives a 32-bit (TIMEOUT=4) and a 64-bit (TIMEOUT=6) unit with identical requests and
// checks every cycle against an arithmetic model of the access rules.
module tb_lsu_aligned;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_aligned_if #(.XLEN(32), .ADDR_W(32)) if32 ();
  lsu_aligned_if #(.XLEN(64), .ADDR_W(32)) if64 ();

  lsu_aligned #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) d32 (.clk(clk), .rst(rst), .io(if32));
  lsu_aligned #(.XLEN(64), .ADDR_W(32), .TIMEOUT(6)) d64 (.clk(clk), .rst(rst), .io(if64));

  int n_cmp = 0;
  int n_bad = 0;
  int xl[2] = '{32, 64};
  int to[2] = '{4, 6};

  logic [63:0] o_bv[2], o_ba[2], o_bw[2], o_be[2], o_wd[2];
  logic [63:0] o_rv[2], o_rd[2], o_er[2], o_busy[2], o_rr[2];

  task automatic chk(input string tag, input int i, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s x%0d: observed %0h expected %0h", tag, xl[i], obs, exp);
    end
  endtask

  task automatic sample();
    o_bv[0] = 64'(if32.bus_valid);   o_bv[1] = 64'(if64.bus_valid);
    o_ba[0] = 64'(if32.bus_addr);    o_ba[1] = 64'(if64.bus_addr);
    o_bw[0] = 64'(if32.bus_write);   o_bw[1] = 64'(if64.bus_write);
    o_be[0] = 64'(if32.bus_byte_en); o_be[1] = 64'(if64.bus_byte_en);
    o_wd[0] = 64'(if32.bus_wdata);   o_wd[1] = 64'(if64.bus_wdata);
    o_rv[0] = 64'(if32.resp_valid);  o_rv[1] = 64'(if64.resp_valid);
    o_rd[0] = 64'(if32.resp_rdata);  o_rd[1] = 64'(if64.resp_rdata);
    o_er[0] = 64'(if32.resp_err);    o_er[1] = 64'(if64.resp_err);
    o_busy[0] = 64'(if32.busy);      o_busy[1] = 64'(if64.busy);
    o_rr[0] = 64'(if32.req_ready);   o_rr[1] = 64'(if64.req_ready);
  endtask

  // Load result from the spec rules: select bytes at the offset, keep 8<<size bits, extend.
  function automatic logic [63:0] ld_model(input int xlen, input logic [1:0] sz, input logic uns,
                                           input int off, input logic [63:0] rd);
    logic [63:0] xm, v, m;
    int bits;
    xm   = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    bits = 8 << sz;
    v    = (rd & xm) >> (8 * off);
    m    = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
    v    = v & m;
    if (!uns && v[bits-1]) v = v | ~m;
    return v & xm;
  endfunction

  task automatic set_req(input logic vld, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [63:0] wd);
    if32.req_valid = vld; if32.req_write = wr; if32.req_size = sz; if32.req_unsigned = uns;
    if32.req_addr = addr; if32.req_wdata = wd[31:0];
    if64.req_valid = vld; if64.req_write = wr; if64.req_size = sz; if64.req_unsigned = uns;
    if64.req_addr = addr; if64.req_wdata = wd;
  endtask

  // k = BUS cycle (1-based) on which bus_ready is raised; out-of-range means never.
  task automatic run_txn(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [63:0] wd,
                         input logic [63:0] rd0, input logic [63:0] rd1, input int k0, input int k1);
    int n[2], k[2], off, last;
    logic [1:0] er[2];
    logic [63:0] erd[2], ebe[2], ewd[2], eba[2], rdv[2], xm;
    k[0] = k0; k[1] = k1; rdv[0] = rd0; rdv[1] = rd1;
    for (int i = 0; i < 2; i++) begin
      xm     = (xl[i] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
      off    = int'(addr % (xl[i] / 8));
      eba[i] = 64'(addr - 32'(off));
      ebe[i] = (((64'd1 << (1 << sz)) - 64'd1) << off) & ((64'd1 << (xl[i] / 8)) - 64'd1);
      ewd[i] = ((wd & xm) << (8 * off)) & xm;
      erd[i] = 64'd0;
      if (sz == 2'b11 && xl[i] == 32) begin
        n[i] = 0; er[i] = 2'b11;
      end else if ((addr % (32'd1 << sz)) != 0) begin
        n[i] = 0; er[i] = 2'b01;
      end else if (k[i] >= 1 && k[i] <= to[i]) begin
        n[i] = k[i]; er[i] = 2'b00;
        if (!wr) erd[i] = ld_model(xl[i], sz, uns, off, rdv[i]);
      end else begin
        n[i] = to[i]; er[i] = 2'b10;
      end
    end
    set_req(1'b1, wr, sz, uns, addr, wd);
    sample();
    for (int i = 0; i < 2; i++) chk({tag, " req_ready"}, i, o_rr[i], 64'd1);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 64'd0);
    last = ((n[0] > n[1]) ? n[0] : n[1]) + 2;
    for (int c = 1; c <= last; c++) begin
      if32.bus_ready = (c == k[0]); if32.bus_rdata = rdv[0][31:0];
      if64.bus_ready = (c == k[1]); if64.bus_rdata = rdv[1];
      sample();
      for (int i = 0; i < 2; i++) begin
        if (c <= n[i]) begin
          chk({tag, " bus_valid"}, i, o_bv[i], 64'd1);
          chk({tag, " bus_addr"}, i, o_ba[i], eba[i]);
          chk({tag, " bus_byte_en"}, i, o_be[i], ebe[i]);
          chk({tag, " bus_write"}, i, o_bw[i], 64'(wr));
          if (wr) chk({tag, " bus_wdata"}, i, o_wd[i], ewd[i]);
          chk({tag, " resp_valid_early"}, i, o_rv[i], 64'd0);
        end else if (c == n[i] + 1) begin
          chk({tag, " bus_valid_resp"}, i, o_bv[i], 64'd0);
          chk({tag, " bus_byte_en_idle"}, i, o_be[i], 64'd0);
          chk({tag, " bus_write_idle"}, i, o_bw[i], 64'd0);
          chk({tag, " resp_valid"}, i, o_rv[i], 64'd1);
          chk({tag, " resp_err"}, i, o_er[i], 64'(er[i]));
          chk({tag, " resp_rdata"}, i, o_rd[i], erd[i]);
        end else begin
          chk({tag, " resp_valid_late"}, i, o_rv[i], 64'd0);
          chk({tag, " busy_late"}, i, o_busy[i], 64'd0);
        end
      end
      @(posedge clk); #1;
    end
    if32.bus_ready = 1'b0; if64.bus_ready = 1'b0;
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [63:0] rd;
    rst = 1'b0;
    set_req(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 64'd0);
    if32.bus_ready = 1'b0; if32.bus_rdata = '0;
    if64.bus_ready = 1'b0; if64.bus_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    sample();
    for (int i = 0; i < 2; i++) begin
      chk("rst bus_valid", i, o_bv[i], 64'd0);
      chk("rst bus_write", i, o_bw[i], 64'd0);
      chk("rst bus_byte_en", i, o_be[i], 64'd0);
      chk("rst bus_addr", i, o_ba[i], 64'd0);
      chk("rst bus_wdata", i, o_wd[i], 64'd0);
      chk("rst resp_valid", i, o_rv[i], 64'd0);
      chk("rst resp_rdata", i, o_rd[i], 64'd0);
      chk("rst resp_err", i, o_er[i], 64'd0);
      chk("rst busy", i, o_busy[i], 64'd0);
    end
    rst = 1'b1;
    #1;
    sample();
    for (int i = 0; i < 2; i++) chk("rst req_ready", i, o_rr[i], 64'd1);
    @(posedge clk); #1;

    run_txn("lb_signed",  1'b0, 2'b00, 1'b0, 32'h103, 64'd0, 64'h80AA_BBCC, 64'h80AA_BBCC, 1, 1);
    run_txn("sh_store",   1'b1, 2'b01, 1'b0, 32'h202, 64'hBEEF, 64'd0, 64'd0, 1, 1);
    run_txn("lw_misal",   1'b0, 2'b10, 1'b0, 32'h6, 64'd0, 64'hFFFF, 64'hFFFF, 1, 1);
    run_txn("timeout",    1'b0, 2'b10, 1'b0, 32'h10, 64'd0, 64'h1234, 64'h1234, 0, 0);
    run_txn("ready_last", 1'b0, 2'b10, 1'b0, 32'h10, 64'd0, 64'h8000_0001, 64'h8000_0001, 4, 6);
    run_txn("lwu_64",     1'b0, 2'b10, 1'b1, 32'h14, 64'd0, 64'h8765_4321,
            64'h8765_4321_0000_0000, 2, 2);
    run_txn("size11",     1'b0, 2'b11, 1'b0, 32'h18, 64'd0, 64'h0, 64'hF123_4567_89AB_CDEF, 1, 1);

    // Reset while on the bus with bus_ready high must drop the transaction silently.
    set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 64'd0);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 64'd0);
    sample();
    for (int i = 0; i < 2; i++) chk("mid_rst bus_valid", i, o_bv[i], 64'd1);
    if32.bus_ready = 1'b1; if64.bus_ready = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
    sample();
    for (int i = 0; i < 2; i++) begin
      chk("mid_rst resp_valid", i, o_rv[i], 64'd0);
      chk("mid_rst busy", i, o_busy[i], 64'd0);
      chk("mid_rst bus_valid_off", i, o_bv[i], 64'd0);
    end
    rst = 1'b1;
    if32.bus_ready = 1'b0; if64.bus_ready = 1'b0;
    #1;
    sample();
    for (int i = 0; i < 2; i++) chk("mid_rst req_ready", i, o_rr[i], 64'd1);
    @(posedge clk); #1;
    sample();
    for (int i = 0; i < 2; i++) chk("mid_rst no_resp", i, o_rv[i], 64'd0);

    for (int t = 0; t < 80; t++) begin
      sz   = 2'($urandom_range(0, 3));
      addr = 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
      rd   = {$urandom, $urandom};
      run_txn("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr,
              {$urandom, $urandom}, rd, {$urandom, $urandom},
              int'($urandom_range(0, 7)), int'($urandom_range(0, 8)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
